result_packer: RTL and testbench
================================

Name: result_packer

Overview:
- Downstream stage of the three-input add/sub top, whose 1-bit `result` stream feeds this block.
- Collects serial result bits, LSB first, into WORD_W-bit words.
- Tags each word with its valid-bit count and ones count.
- Delivers words through a 2-entry output FIFO on a valid/ready interface, with backpressure to the producer and a flush for partial words.

Parameters:
- WORD_W, 8, bits per packed word (≥2).
- CNT_W, 4, width of length/ones fields; must be ≥ clog2(WORD_W+1).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial result bit from the add/sub top.
- in_ready  output  1  block accepts in_bit this cycle.
- flush  input  1  request emission of the current partial word.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the FIFO head.
- out_word  output  WORD_W  packed word, bit 0 = first bit received, unused bits 0.
- out_len  output  CNT_W  number of valid bits in out_word (1..WORD_W).
- out_ones  output  CNT_W  popcount of out_word.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset (including mid-word): bit_idx=0, shift register=0, running ones=0, FIFO empty, flush_pend=0.
  - Outputs after reset: out_valid=0, out_word=0, out_len=0, out_ones=0, in_ready=1.
  - Any partial word is discarded.
- Bit accept: when in_valid & in_ready, in_bit is written to position bit_idx, bit_idx increments, and running ones increments if in_bit=1.
- Word complete:
  - When the accepted bit has bit_idx==WORD_W-1, push {word, WORD_W, ones} into the FIFO in the same edge.
  - Then clear bit_idx, the shift register and ones.
- in_ready = !(bit_idx==WORD_W-1 && fifo_count==2) && !flush_pend.
  - No combinational path from out_ready to in_ready; a pop in the same cycle does not free a slot for that cycle's push.
- Flush:
  - flush with bit_idx==0 and no bit accepted this cycle: no-op.
  - Otherwise flush sets flush_pend.
  - While flush_pend and fifo_count<2: push {word zero-padded, bit_idx, ones}, clear the partial state and flush_pend.
  - A bit accepted in the same cycle as flush is included in the flushed word.
  - If that bit completes the word, the normal full-word push occurs, flush_pend is cleared, and no extra empty word is emitted.
- FIFO:
  - 2 entries, in-order.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle with count==2 is legal (count stays 2).
  - Outputs are driven from the head entry register, giving 1-cycle latency from push to out_valid.
  - out_word/out_len/out_ones hold stable while out_valid & !out_ready.
- Latency: the last bit of a word is accepted at edge N; out_valid is high after edge N if the FIFO was empty.
- Arithmetic: ones and len never exceed WORD_W, so there is no wrap.
- bit_idx wraps to 0 only via word completion, flush or reset.

Test Plan:
- WORD_W=8, out_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> one cycle after the 8th bit: out_valid=1, out_word=0x4D, out_len=8, out_ones=4.
- Bits 1,1,0 then flush=1 for one cycle -> out_word=0x03, out_len=3, out_ones=2; the next word starts at bit 0.
- out_ready=0, 24 consecutive 1-bits offered with in_valid=1:
  - two 0xFF words are buffered;
  - in_ready=0 with bit_idx=7 while the FIFO is full.
  - Then raise out_ready: 0xFF, 0xFF drain in order, in_ready returns the cycle after the first pop, and the third word 0xFF/len 8/ones 8 follows.
- 5 bits accepted, then rst=1 for one cycle, then bits 0,0,0,0,0,0,0,1 -> a single word 0x80, len 8, ones 1; no partial word emitted.
- flush with bit_idx=0 -> no output. Flush asserted together with the 8th bit 1 (word all 1s) -> exactly one word 0xFF, len 8, ones 8.
- FIFO full plus flush after 4 bits 1,0,1,0 -> flush_pend holds and in_ready=0. After one pop, the word 0x05, len 4, ones 2 is pushed.

Source files
------------

// File: rtl/result_packer.sv
// Packs a serial LSB-first bit stream into WORD_W-bit words, each tagged with
// its length and ones count, and delivers them through a 2-entry valid/ready FIFO.
module result_packer #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [CNT_W-1:0]  out_len,
  output logic [CNT_W-1:0]  out_ones
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(WORD_W);

  logic [CNT_W-1:0]  r_bit_idx;
  logic [WORD_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_ones;
  logic              r_flush_pend;

  logic [1:0]        r_count;
  logic [WORD_W-1:0] r_head_word, r_tail_word;
  logic [CNT_W-1:0]  r_head_len,  r_tail_len;
  logic [CNT_W-1:0]  r_head_ones, r_tail_ones;

  logic              w_accept;
  logic              w_last;
  logic              w_full_push;
  logic              w_flush_push;
  logic              w_flush_set;
  logic              w_push;
  logic              w_pop;
  logic [WORD_W-1:0] w_new_shift;
  logic [CNT_W-1:0]  w_new_ones;
  logic [WORD_W-1:0] w_push_word;
  logic [CNT_W-1:0]  w_push_len;
  logic [CNT_W-1:0]  w_push_ones;

  // in_ready depends on registered state only, so out_ready never reaches it.
  assign w_last   = (r_bit_idx == LAST_IDX);
  assign in_ready = !(w_last && (r_count == 2'd2)) && !r_flush_pend;
  assign w_accept = in_valid && in_ready;

  // Positions at and above r_bit_idx are always zero, so OR-ing inserts the bit.
  assign w_new_shift = r_shift | ((w_accept && in_bit) ? (WORD_W'(1) << r_bit_idx) : '0);
  assign w_new_ones  = r_ones + {{(CNT_W-1){1'b0}}, (w_accept && in_bit)};

  // A pending flush blocks acceptance, so at most one push source is active.
  assign w_full_push  = w_accept && w_last;
  assign w_flush_push = r_flush_pend && (r_count != 2'd2);
  assign w_push       = w_full_push || w_flush_push;
  assign w_pop        = (r_count != 2'd0) && out_ready;
  assign w_flush_set  = flush && !r_flush_pend && !w_full_push &&
                        ((r_bit_idx != '0) || w_accept);

  assign w_push_word = w_full_push ? w_new_shift : r_shift;
  assign w_push_len  = w_full_push ? FULL_LEN    : r_bit_idx;
  assign w_push_ones = w_full_push ? w_new_ones  : r_ones;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_ones       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_push) begin
        r_bit_idx <= '0;
        r_shift   <= '0;
        r_ones    <= '0;
      end else if (w_accept) begin
        r_bit_idx <= r_bit_idx + 1'b1;
        r_shift   <= w_new_shift;
        r_ones    <= w_new_ones;
      end
      if (w_flush_push) begin
        r_flush_pend <= 1'b0;
      end else if (w_flush_set) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  // Two-entry FIFO: head drives the outputs, tail holds the second word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= 2'd0;
      r_head_word <= '0;
      r_head_len  <= '0;
      r_head_ones <= '0;
      r_tail_word <= '0;
      r_tail_len  <= '0;
      r_tail_ones <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head_word <= w_push_word;
            r_head_len  <= w_push_len;
            r_head_ones <= w_push_ones;
            r_count     <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head_word <= w_push_word;
            r_head_len  <= w_push_len;
            r_head_ones <= w_push_ones;
          end else if (w_push) begin
            r_tail_word <= w_push_word;
            r_tail_len  <= w_push_len;
            r_tail_ones <= w_push_ones;
            r_count     <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head_word <= r_tail_word;
            r_head_len  <= r_tail_len;
            r_head_ones <= r_tail_ones;
            if (w_push) begin
              r_tail_word <= w_push_word;
              r_tail_len  <= w_push_len;
              r_tail_ones <= w_push_ones;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign out_valid = (r_count != 2'd0);
  assign out_word  = r_head_word;
  assign out_len   = r_head_len;
  assign out_ones  = r_head_ones;

endmodule

// File: tb/tb_result_packer.sv
// Directed and random stimulus for result_packer, checked against a
// queue-based model of the packing and FIFO rules.
module tb_result_packer;
  localparam int W = 8;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_bit, in_ready, flush;
  logic         out_valid, out_ready;
  logic [W-1:0] out_word;
  logic [C-1:0] out_len, out_ones;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int word;
    int len;
    int ones;
  } ent_t;

  bit   mbits[$];
  ent_t mfifo[$];
  bit   mpend = 1'b0;

  result_packer #(.WORD_W(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_len(out_len),
    .out_ones(out_ones)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t make_ent();
    ent_t e;
    e.word = 0;
    e.ones = 0;
    e.len  = mbits.size();
    for (int i = 0; i < mbits.size(); i++) begin
      if (mbits[i]) begin
        e.word += (1 << i);
        e.ones++;
      end
    end
    return e;
  endfunction

  function automatic bit exp_ready();
    return !((mbits.size() == W - 1) && (mfifo.size() == 2)) && !mpend;
  endfunction

  task automatic compare_outputs();
    check("in_ready", in_ready, exp_ready());
    check("out_valid", out_valid, (mfifo.size() != 0));
    if (mfifo.size() != 0) begin
      check("out_word", out_word, mfifo[0].word);
      check("out_len", out_len, mfifo[0].len);
      check("out_ones", out_ones, mfifo[0].ones);
    end
  endtask

  task automatic step(input bit v, input bit b, input bit f, input bit r, input bit rs = 1'b0);
    bit rdy;
    bit full;
    int pre_size;
    compare_outputs();
    rdy       = exp_ready();
    in_valid  = v;
    in_bit    = b;
    flush     = f;
    out_ready = r;
    rst       = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      mbits.delete();
      mfifo.delete();
      mpend = 1'b0;
    end else begin
      pre_size = mfifo.size();
      if (pre_size > 0 && r) void'(mfifo.pop_front());
      if (mpend) begin
        if (pre_size < 2) begin
          mfifo.push_back(make_ent());
          mbits.delete();
          mpend = 1'b0;
        end
      end else begin
        full = 1'b0;
        if (v && rdy) begin
          mbits.push_back(b);
          if (mbits.size() == W) begin
            mfifo.push_back(make_ent());
            mbits.delete();
            full = 1'b1;
          end
        end
        if (f && !full && mbits.size() != 0) mpend = 1'b1;
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_len", out_len, 0);
    check("rst_out_ones", out_ones, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();

    // Basic word 0x4D
    pat = 8'h4D;
    for (int i = 0; i < 8; i++) step(1'b1, pat[i], 1'b0, 1'b1);
    check("w4d_valid", out_valid, 1);
    check("w4d_word", out_word, 8'h4D);
    check("w4d_len", out_len, 8);
    check("w4d_ones", out_ones, 4);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Partial flush 1,1,0
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("fl3_valid", out_valid, 1);
    check("fl3_word", out_word, 8'h03);
    check("fl3_len", out_len, 3);
    check("fl3_ones", out_ones, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure with 24 ones offered
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("bp_in_ready", in_ready, 0);
    check("bp_valid", out_valid, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_ready_back", in_ready, 1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word discards the partial word
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_reset_outputs();
    for (int i = 0; i < 8; i++) step(1'b1, (i == 7), 1'b0, 1'b1);
    check("w80_word", out_word, 8'h80);
    check("w80_len", out_len, 8);
    check("w80_ones", out_ones, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Flush at bit_idx 0, then flush with the completing bit
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("fl0_no_out", out_valid, 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("flff_word", out_word, 8'hFF);
    check("flff_len", out_len, 8);
    check("flff_ones", out_ones, 8);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("flff_no_extra", out_valid, 0);

    // Flush pending while the FIFO is full
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, (i % 2 == 0), 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("pend_in_ready", in_ready, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("pend_word", out_word, 8'h05);
    check("pend_len", out_len, 4);
    check("pend_ones", out_ones, 2);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 199) == 0));
    end
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);
    compare_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
